// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 datapath mux among four valid/ready requesters,
// with a one-entry registered output stage and a wrapping grant counter.
module mux4x1_6bit #(
    parameter int W = 6
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic [W-1:0] out
);
    always_comb begin
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end
endmodule

module mux4_rr_arbiter #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        in_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [DATA_W-1:0] in1_data,
    input  logic [DATA_W-1:0] in2_data,
    input  logic [DATA_W-1:0] in3_data,
    output logic [3:0]        in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  grant_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         win;
    logic [1:0]         idx;
    logic               found;
    logic               can_load;
    logic               xfer;
    logic [DATA_W-1:0]  mux_out;

    // Scan from the priority pointer upward; first pending requester wins.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && in_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    mux4x1_6bit #(.W(DATA_W)) u_mux (
        .sel (win),
        .in0 (in0_data),
        .in1 (in1_data),
        .in2 (in2_data),
        .in3 (in3_data),
        .out (mux_out)
    );

    assign can_load = (state_q == EMPTY) || out_ready;
    // Reset gates the handshake so nothing is accepted during a reset cycle.
    assign xfer     = rst_n && can_load && (|in_valid);
    assign in_ready = xfer ? (4'b0001 << win) : 4'b0000;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            state_d = FULL;
            data_d  = mux_out;
            sel_d   = win;
            ptr_d   = win + 2'd1;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign grant_cnt = cnt_q;
endmodule
